// File: rtl/shift_pkg.sv
// Shared types and default widths for the multi-cycle shift sequencer.
package shift_pkg;

  typedef enum logic [1:0] {
    SLL  = 2'b00,
    SRL  = 2'b01,
    SRA  = 2'b10,
    RSVD = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } seq_state_t;

  localparam int NB_BITS_DATA  = 32;
  localparam int NB_BITS_SHIFT = 5;

endpackage

// File: rtl/shift_stage_unit.sv
// One power-of-two shift stage: shifts by 2**k_i when en_i is set, else passes data through.
module shift_stage_unit
  import shift_pkg::*;
#(
  parameter int nb_bits_data  = NB_BITS_DATA,
  parameter int nb_bits_shift = NB_BITS_SHIFT,
  parameter int kw            = $clog2(nb_bits_shift) + 1
) (
  input  logic [nb_bits_data-1:0] data_i,
  input  logic [1:0]              op_i,
  input  logic [kw-1:0]           k_i,
  input  logic                    en_i,
  output logic [nb_bits_data-1:0] data_o
);

  logic [nb_bits_shift-1:0][nb_bits_data-1:0] sll_s;
  logic [nb_bits_shift-1:0][nb_bits_data-1:0] srl_s;
  logic [nb_bits_shift-1:0][nb_bits_data-1:0] sra_s;
  logic [nb_bits_data-1:0]                    sel_s;

  // Stages whose distance reaches the data width saturate to zero or sign fill.
  for (genvar g = 0; g < nb_bits_shift; g++) begin : g_stage
    localparam int unsigned DIST = 2 ** g;
    if (DIST < nb_bits_data) begin : g_in_range
      assign sll_s[g] = data_i << DIST;
      assign srl_s[g] = data_i >> DIST;
      assign sra_s[g] = $signed(data_i) >>> DIST;
    end else begin : g_out_range
      assign sll_s[g] = {nb_bits_data{1'b0}};
      assign srl_s[g] = {nb_bits_data{1'b0}};
      assign sra_s[g] = {nb_bits_data{data_i[nb_bits_data-1]}};
    end
  end

  always_comb begin
    sel_s = data_i;
    for (int i = 0; i < nb_bits_shift; i++) begin
      if (k_i == i[kw-1:0]) begin
        case (op_i)
          SLL:     sel_s = sll_s[i];
          SRA:     sel_s = sra_s[i];
          default: sel_s = srl_s[i];
        endcase
      end
    end
  end

  assign data_o = en_i ? sel_s : data_i;

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA unit: one power-of-two stage per clock, early exit
// once the remaining shift-amount bits are zero, valid/ready on both sides.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int nb_bits_data  = NB_BITS_DATA,
  parameter int nb_bits_shift = NB_BITS_SHIFT
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  output logic                     ready_o,
  input  logic [1:0]               op_i,
  input  logic [nb_bits_data-1:0]  data_i,
  input  logic [nb_bits_shift-1:0] shift_value_i,
  input  logic                     flush_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [nb_bits_data-1:0]  result_o,
  output logic                     busy_o
);

  localparam int KW = $clog2(nb_bits_shift) + 1;

  seq_state_t               state_q,  state_d;
  logic [nb_bits_data-1:0]  data_q,   data_d;
  logic [nb_bits_data-1:0]  result_q, result_d;
  logic [nb_bits_shift-1:0] amt_q,    amt_d;
  logic [KW-1:0]            k_q,      k_d;
  shift_op_t                op_q,     op_d;

  logic                     ready_s;
  logic                     accept_s;
  logic [nb_bits_data-1:0]  stage_s;
  logic [nb_bits_shift-1:0] amt_next_s;

  shift_stage_unit #(
    .nb_bits_data  (nb_bits_data),
    .nb_bits_shift (nb_bits_shift),
    .kw            (KW)
  ) u_stage (
    .data_i (data_q),
    .op_i   (op_q),
    .k_i    (k_q),
    .en_i   (amt_q[0]),
    .data_o (stage_s)
  );

  assign amt_next_s = amt_q >> 1;

  // Next-state, datapath update and handshake decode.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    result_d = result_q;
    amt_d    = amt_q;
    k_d      = k_q;
    op_d     = op_q;
    ready_s  = ((state_q == IDLE) || ((state_q == DONE) && ready_i)) && !flush_i;
    accept_s = start_i && ready_s;

    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept_s) begin
            data_d = data_i;
            amt_d  = shift_value_i;
            op_d   = shift_op_t'(op_i);
            k_d    = {KW{1'b0}};
            if (shift_value_i == {nb_bits_shift{1'b0}}) begin
              state_d  = DONE;
              result_d = data_i;
            end else begin
              state_d = RUN;
            end
          end else if ((state_q == DONE) && ready_i) begin
            state_d = IDLE;
          end else begin
            state_d = state_q;
          end
        end
        RUN: begin
          data_d = stage_s;
          amt_d  = amt_next_s;
          k_d    = k_q + {{(KW-1){1'b0}}, 1'b1};
          if (amt_next_s == {nb_bits_shift{1'b0}}) begin
            state_d  = DONE;
            result_d = stage_s;
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      data_q   <= {nb_bits_data{1'b0}};
      result_q <= {nb_bits_data{1'b0}};
      amt_q    <= {nb_bits_shift{1'b0}};
      k_q      <= {KW{1'b0}};
      op_q     <= SLL;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      result_q <= result_d;
      amt_q    <= amt_d;
      k_q      <= k_d;
      op_q     <= op_d;
    end
  end

  assign ready_o  = ready_s;
  assign valid_o  = (state_q == DONE);
  assign busy_o   = (state_q == RUN) || (state_q == DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer.
module tb_shift_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        ready_o;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] data_i = 32'h0;
  logic [4:0]  shift_value_i = 5'd0;
  logic        flush_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] result_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  shift_sequencer #(.nb_bits_data(32), .nb_bits_shift(5)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .ready_o       (ready_o),
    .op_i          (op_i),
    .data_i        (data_i),
    .shift_value_i (shift_value_i),
    .flush_i       (flush_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .result_o      (result_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one op from IDLE, wait for valid_o, check latency and result.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] d,
                        input logic [4:0] amt, input logic [31:0] exp_res, input int exp_lat);
    int cyc;
    n_checks++;
    if (ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_before: got %b want 1", name, ready_o);
    end
    start_i = 1'b1; op_i = op; data_i = d; shift_value_i = amt;
    tick();
    start_i = 1'b0;
    cyc = 1;
    while (valid_o !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc !== exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
    end
    n_checks++;
    if (result_o !== exp_res) begin
      n_fail++;
      $display("FAIL %s result: got %h want %h", name, result_o, exp_res);
    end
    tick();
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || busy_o !== 1'b0 || result_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b r=%b b=%b res=%h want 0 1 0 0",
               valid_o, ready_o, busy_o, result_o);
    end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_shifts();
    run_op("srl_31", 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 6);
    run_op("sra_4",  2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000, 4);
    run_op("srl_4",  2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000, 4);
    run_op("rsvd_4", 2'b11, 32'h8000_0000, 5'd4,  32'h0800_0000, 4);
    run_op("sll_0",  2'b00, 32'h0000_0001, 5'd0,  32'h0000_0001, 1);
    run_op("sll_5",  2'b00, 32'h0000_0003, 5'd5,  32'h0000_0060, 4);
    run_op("sra_31", 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 6);
    run_op("sll_31", 2'b00, 32'h0000_0003, 5'd31, 32'h8000_0000, 6);
  endtask

  task automatic test_reset_mid_run();
    start_i = 1'b1; op_i = 2'b01; data_i = 32'hFFFF_0000; shift_value_i = 5'd16;
    tick();
    start_i = 1'b0;
    tick();
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || busy_o !== 1'b0 || result_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got v=%b r=%b b=%b res=%h want 0 1 0 0",
               valid_o, ready_o, busy_o, result_o);
    end
    tick();
    rst_ni = 1'b1;
    tick();
    run_op("after_reset", 2'b01, 32'hFFFF_0000, 5'd16, 32'h0000_FFFF, 6);
  endtask

  task automatic test_back_to_back();
    logic [31:0] held;
    int cyc;
    ready_i = 1'b0;
    start_i = 1'b1; op_i = 2'b00; data_i = 32'h3; shift_value_i = 5'd5;
    tick();
    start_i = 1'b0;
    cyc = 1;
    while (valid_o !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    held = result_o;
    n_checks++;
    if (held !== 32'h60) begin
      n_fail++;
      $display("FAIL bp_result: got %h want 00000060", held);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (valid_o !== 1'b1 || result_o !== 32'h60 || ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b res=%h r=%b want 1 00000060 0",
                 i, valid_o, result_o, ready_o);
      end
    end
    ready_i = 1'b1;
    start_i = 1'b1; op_i = 2'b01; data_i = 32'h100; shift_value_i = 5'd8;
    #1;
    n_checks++;
    if (ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: got %b want 1", ready_o);
    end
    tick();
    start_i = 1'b0;
    n_checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_drop: got v=%b b=%b want 0 1", valid_o, busy_o);
    end
    cyc = 1;
    while (valid_o !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc !== 5 || result_o !== 32'h1) begin
      n_fail++;
      $display("FAIL b2b_result: got cyc=%0d res=%h want 5 00000001", cyc, result_o);
    end
    tick();
  endtask

  task automatic test_flush();
    logic [31:0] prev;
    int seen_valid;
    prev = result_o;
    start_i = 1'b1; op_i = 2'b00; data_i = 32'h1; shift_value_i = 5'd16;
    tick();
    start_i = 1'b0;
    tick();
    flush_i = 1'b1;
    start_i = 1'b1; op_i = 2'b00; data_i = 32'h5; shift_value_i = 5'd0;
    #1;
    n_checks++;
    if (ready_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_ready: got r=%b b=%b want 0 1", ready_o, busy_o);
    end
    tick();
    flush_i = 1'b0;
    start_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0 || result_o !== prev) begin
      n_fail++;
      $display("FAIL flush_idle: got b=%b v=%b res=%h want 0 0 %h", busy_o, valid_o, result_o, prev);
    end
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      if (valid_o === 1'b1 || busy_o === 1'b1) seen_valid++;
      tick();
    end
    n_checks++;
    if (seen_valid !== 0) begin
      n_fail++;
      $display("FAIL flush_quiet: got %0d active cycles want 0", seen_valid);
    end
    run_op("after_flush", 2'b00, 32'h1, 5'd16, 32'h0001_0000, 6);
  endtask

  initial begin
    test_reset();
    test_shifts();
    test_reset_mid_run();
    test_back_to_back();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle shift unit for the integer datapath. It applies one power-of-two shift stage per clock instead of a full combinational barrel shifter.
- Trades latency for area and removes the long shift path from the critical timing path.
- Supports SLL, SRL and SRA, with a valid/ready handshake on both input and output.
- Terminates early once the remaining shift-amount bits are zero.

Parameters:
- nb_bits_data, 32: data width.
- nb_bits_shift, 5: shift-amount width. If 2**nb_bits_shift > nb_bits_data, out-of-range stages produce all-zero (SLL/SRL) or all-sign (SRA).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  request valid.
- ready_o  out  1  request accepted when start_i & ready_o.
- op_i  in  2  shift_op_t: SLL=00, SRL=01, SRA=10, 11 executes as SRL.
- data_i  in  nb_bits_data  operand.
- shift_value_i  in  nb_bits_shift  shift amount.
- flush_i  in  1  synchronous abort.
- valid_o  out  1  result available.
- ready_i  in  1  consumer accepts result when valid_o & ready_i.
- result_o  out  nb_bits_data  shifted result, registered.
- busy_o  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - state=IDLE, result_o=0, valid_o=0, busy_o=0, ready_o=1.
  - Internal amt_q=0, k_q=0, op_q=SLL.
- States: IDLE, RUN, DONE.
- ready_o = (state==IDLE) | (state==DONE & ready_i). It is combinational from state and ready_i.
- valid_o = (state==DONE).
- Accept (start_i & ready_o, no flush_i):
  - Captures data_q<=data_i, amt_q<=shift_value_i, op_q<=op_i, k_q<=0.
  - Next state is RUN if shift_value_i!=0, otherwise DONE.
- RUN, each cycle:
  - If amt_q[0], data_q is shifted by 2**k_q per op_q. SLL and SRL zero-fill; SRA fills with data_q MSB.
  - amt_q<=amt_q>>1, k_q<=k_q+1.
  - If (amt_q>>1)==0, next state is DONE; otherwise stay in RUN.
  - start_i is ignored (ready_o=0).
- Latency (acceptance cycle = cycle 0):
  - Shift 0: valid_o high in cycle 1.
  - Otherwise, with m = index of the highest set bit of the shift amount: RUN occupies cycles 1..m+1 and valid_o is high in cycle m+2.
  - Maximum (amount 31): valid_o in cycle 6.
- DONE:
  - result_o (= data_q) and valid_o are held stable while ready_i=0.
  - On ready_i: if start_i is also high, a new op is accepted in the same cycle (no bubble) and the next state follows the accept rule. Otherwise the next state is IDLE.
- flush_i (synchronous, highest priority after reset):
  - Next state is IDLE and valid_o drops next cycle.
  - Any start_i in the same cycle is not accepted (ready_o is forced to 0 when flush_i=1).
  - result_o keeps its last value.
- Reset mid-RUN or mid-DONE: immediate return to the reset values above; the in-flight op is lost.
- k_q is never compared against nb_bits_shift; termination comes only from amt_q reaching zero.

Decomposition:
- Package shift_pkg:
  - shift_op_t enum (SLL, SRL, SRA, RSVD).
  - seq_state_t enum (IDLE, RUN, DONE).
  - Default width constants.
- Sub-module shift_stage_unit (combinational):
  - Inputs: data, op, k (stage index), enable.
  - Output: data shifted by 2**k when enabled, else passthrough.
  - Built as a k-indexed mux of fixed power-of-two shifts.
- The sequencer holds the FSM, amt_q, k_q and data_q.

Test Plan:
- Assert rst_ni low during RUN of SRL 0xFFFF0000 by 16 → valid_o=0, ready_o=1, busy_o=0, result_o=0 immediately. After release, a new op completes normally.
- SRL 0x80000000 by 31 → RUN in cycles 1-5, valid_o in cycle 6, result 0x00000001.
- SRA 0x80000000 by 4 → valid_o in cycle 4, result 0xF8000000. Same with SRL gives 0x08000000. Op 11 gives 0x08000000.
- SLL 0x00000001 by 0 → valid_o in cycle 1, result 0x00000001. SLL 0x00000003 by 5 → valid_o in cycle 4, result 0x00000060.
- Backpressure: hold ready_i=0 for 3 cycles in DONE → result_o/valid_o stable, ready_o=0. Then ready_i=1 with start_i=1 (SRL 0x100 by 8) → accepted that cycle, valid_o drops next cycle, result 0x1 appears in cycle 5.
- flush_i in cycle 2 of SLL 0x1 by 16 → IDLE next cycle, valid_o never asserts, start_i in the flush cycle not accepted.
